// File: rtl/fp_ftoi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fp_ftoi_arbiter_pkg
// Shared definitions for the fp32-to-int32 converter sharing block:
//   DATA_WIDTH   - operand/result width (fp32 in, int32 out)
//   FTOI_LATENCY - pipeline depth of the shared fp_ftoi converter
//   ftoi_tag_t   - {valid, id} tag that follows each operation through the
//                  converter so the result can be routed back to its owner
// -----------------------------------------------------------------------------
package fp_ftoi_arbiter_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned FTOI_LATENCY = 2;

  // The tag id is sized for the largest supported requester count (8), so one
  // tag type serves every NUM_REQ from 2 to 8.
  localparam int unsigned MAX_REQ  = 8;
  localparam int unsigned TAG_ID_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } ftoi_tag_t;

  localparam ftoi_tag_t TAG_IDLE = '{valid: 1'b0, id: {TAG_ID_W{1'b0}}};

  // Build a valid tag for requester req_id.
  function automatic ftoi_tag_t make_tag(input logic [TAG_ID_W-1:0] req_id);
    make_tag = '{valid: 1'b1, id: req_id};
  endfunction

endpackage

// File: rtl/fp_ftoi_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter, reusable by any shared unit.
// The request scan starts just above ptr_i and wraps, so the requester that
// was granted last has the lowest priority.
// Ports:
//   req_i [N]     - request vector
//   ptr_i [PTR_W] - index of the most recent grant
//   gnt_o [N]     - one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Walk ptr+1, ptr+2, ... ptr+N (mod N); the first requester hit wins.
  always_comb begin
    gnt_o   = {N{1'b0}};
    found_s = 1'b0;
    idx_s   = {PTR_W{1'b0}};
    for (int unsigned k = 1; k <= N; k++) begin
      idx_s        = PTR_W'((32'(ptr_i) + k) % N);
      gnt_o[idx_s] = req_i[idx_s] & ~found_s;
      found_s      = found_s | req_i[idx_s];
    end
  end

endmodule

// File: rtl/fp_ftoi_arbiter.sv
// -----------------------------------------------------------------------------
// fp_ftoi_arbiter
// Shares one pipelined fp32-to-int32 converter (fp_ftoi) among NUM_REQ
// requesters. Requests are granted round-robin (one issue per cycle), each
// operation carries its requester id through a tag pipeline that mirrors the
// converter latency, and results land in per-requester response registers
// that are held until the requester accepts them.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_valid_i/ready_o   - per-requester request handshake (ready one-hot)
//   req_data_i            - fp32 operands, requester i at [i*32 +: 32]
//   rsp_valid_o/ready_i   - per-requester response handshake
//   rsp_data_o            - int32 results, same packing as req_data_i
//   fu_float_in_o         - operand to the converter
//   fu_int_result_i       - result from the converter
//   fu_result_valid_i     - converter result valid
//   err_sticky_o          - a tag left the pipeline without a converter result
// -----------------------------------------------------------------------------
module fp_ftoi_arbiter
  import fp_ftoi_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FU_LATENCY = FTOI_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_o,
  output logic [DATA_WIDTH-1:0]         fu_float_in_o,
  input  logic [DATA_WIDTH-1:0]         fu_int_result_i,
  input  logic                          fu_result_valid_i,
  output logic                          err_sticky_o
);

  localparam int unsigned PTR_W      = $clog2(NUM_REQ);
  // One extra stage covers the operand register in front of the converter.
  localparam int unsigned TAG_STAGES = FU_LATENCY + 1;
  // Pointer starts at the top so requester 0 wins the first arbitration.
  localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_s;

  logic [NUM_REQ-1:0] eligible_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [NUM_REQ-1:0] rsp_hs_s;
  logic               issue_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  ftoi_tag_t          last_tag_s;

  logic [PTR_W-1:0]                   ptr_q,       ptr_d;
  logic [NUM_REQ-1:0]                 busy_q,      busy_d;
  logic [DATA_WIDTH-1:0]              operand_q,   operand_d;
  ftoi_tag_t [TAG_STAGES-1:0]         tag_q,       tag_d;
  logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                               err_q,       err_d;

  assign req_data_s = req_data_i;

  // A requester with a result still outstanding may not issue again; busy is
  // registered, so a response handshake only frees the slot next cycle.
  assign eligible_s = req_valid_i & ~busy_q;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (eligible_s),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s)
  );

  assign req_ready_o = gnt_s;
  assign issue_s     = |gnt_s;
  assign rsp_hs_s    = rsp_valid_q & rsp_ready_i;
  assign last_tag_s  = tag_q[TAG_STAGES-1];

  // Encode the one-hot grant into a requester index.
  always_comb begin
    gnt_idx_s = {PTR_W{1'b0}};
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_idx_s = gnt_idx_s | (gnt_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
  end

  // Issue side: pointer, operand register, tag insertion/shift and busy bits.
  always_comb begin
    ptr_d     = ptr_q;
    operand_d = operand_q;
    tag_d[0]  = TAG_IDLE;
    if (issue_s) begin
      ptr_d     = gnt_idx_s;
      operand_d = req_data_s[gnt_idx_s];
      tag_d[0]  = make_tag(TAG_ID_W'(gnt_idx_s));
    end else begin
      // Operand holds its last value so the converter input is quiet when idle.
      ptr_d     = ptr_q;
      operand_d = operand_q;
      tag_d[0]  = TAG_IDLE;
    end
    // The converter never stalls, so the tags shift unconditionally.
    for (int unsigned k = 1; k < TAG_STAGES; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    // A grant and a response handshake never hit the same requester in one
    // cycle (grant needs !busy, a pending response implies busy).
    busy_d = (busy_q | gnt_s) & ~rsp_hs_s;
  end

  // Return side: route the converter result to its owner's buffer and track
  // tag/converter agreement.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (last_tag_s.valid && (last_tag_s.id == TAG_ID_W'(i))) begin
        // The result is stored even if the converter flags it invalid, so
        // the requester is never left waiting; the error is reported instead.
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = fu_int_result_i;
      end else if (rsp_hs_s[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
    err_d = err_q | (last_tag_s.valid & ~fu_result_valid_i);
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= PTR_RESET;
      busy_q      <= {NUM_REQ{1'b0}};
      operand_q   <= {DATA_WIDTH{1'b0}};
      tag_q       <= {$bits(tag_q){1'b0}};
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_data_q  <= {(NUM_REQ*DATA_WIDTH){1'b0}};
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      operand_q   <= operand_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign fu_float_in_o = operand_q;
  assign err_sticky_o  = err_q;

endmodule
